// File: rtl/chroni_render_pkg.sv
// rtl/chroni_render_pkg.sv - shared types and constants for the text line renderer (ATTR_EN widens text data)
package chroni_render_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH_CHAR,
    FETCH_FONT,
    WRITE,
    NEXT
  } render_state_t;

  localparam logic [7:0] PIX_ON  = 8'h01;
  localparam logic [7:0] PIX_OFF = 8'h00;

  localparam int LINE_W_DEFAULT = 640;
  localparam int BUF_DEPTH      = 2 * LINE_W_DEFAULT;
  localparam int BUF_AW         = 11;

`ifdef ATTR_EN
  localparam int TEXT_DW = 16;
`else
  localparam int TEXT_DW = 8;
`endif

  function automatic logic [7:0] mono_pixel(input logic bit_set);
    return bit_set ? PIX_ON : PIX_OFF;
  endfunction

endpackage

// File: rtl/line_buffer_dp.sv
// rtl/line_buffer_dp.sv - 1280x8 line buffer, one write port and one registered read port
module line_buffer_dp
  import chroni_render_pkg::*;
#(
  parameter int DEPTH = BUF_DEPTH,
  parameter int AW    = BUF_AW,
  parameter int DW    = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [0:DEPTH-1];

  // write port; the renderer never produces an address beyond DEPTH-1
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // registered read port; a same-address write in this cycle is not yet visible (old data)
  always_ff @(posedge clk) begin
    if (reset) begin
      rdata <= '0;
    end else if (raddr < AW'(DEPTH)) begin
      rdata <= mem[raddr];
    end else begin
      rdata <= '0;
    end
  end

endmodule

// File: rtl/text_line_renderer.sv
// rtl/text_line_renderer.sv - renders one 8x8 text scan line into a double line buffer; ATTR_EN adds colour attributes
module text_line_renderer
  import chroni_render_pkg::*;
#(
  parameter int COLS      = 80,
  parameter int FONT_ROWS = 8,
  parameter int LINE_W    = LINE_W_DEFAULT,
  parameter int TEXT_AW   = 12,
  parameter int FONT_AW   = 11
) (
  input  logic               vga_clk,
  input  logic               reset,
  input  logic               render_reset,
  input  logic               render_start,
  input  logic               line_advance,
  output logic [TEXT_AW-1:0] text_addr,
  input  logic [TEXT_DW-1:0] text_data,
  output logic [FONT_AW-1:0] font_addr,
  input  logic [7:0]         font_data,
  input  logic [10:0]        pixel_buffer_index_in,
  output logic [7:0]         pixel,
  output logic               busy,
  output logic               line_done,
  output logic               overrun
);

  localparam int COL_W = $clog2(COLS);
  localparam int ROW_W = $clog2(FONT_ROWS);

  render_state_t        state_q;
  render_state_t        state_d;
  logic [COL_W-1:0]     col;
  logic [COL_W-1:0]     col_next;
  logic [BUF_AW-1:0]    wr_ptr;
  logic [2:0]           bit_cnt;
  logic [7:0]           shift_q;
  logic                 write_buf;
  logic                 pending;
  logic [ROW_W-1:0]     scan_row;
  logic [TEXT_AW-1:0]   row_base;
  logic [FONT_AW-1:0]   font_addr_q;
  logic                 last_col;
  logic                 last_bit;
  logic                 cur_bit;
  logic                 adv_buf;
  logic [ROW_W-1:0]     adv_row;
  logic [TEXT_AW-1:0]   adv_base;
  logic                 buf_we;
  logic [7:0]           buf_wdata;
`ifdef ATTR_EN
  logic [7:0]           attr_q;
`endif

  assign last_col = (col == COL_W'(COLS - 1));
  assign last_bit = (bit_cnt == 3'd7);
  assign col_next = col + COL_W'(1);

  // first write cycle takes the bit straight from font RAM, later ones from the shifter
  assign cur_bit = (bit_cnt == 3'd0) ? font_data[7] : shift_q[7];

  // counter values for the line that a queued advance will start
  assign adv_buf  = ~write_buf;
  assign adv_row  = scan_row + ROW_W'(1);
  assign adv_base = (scan_row == ROW_W'(FONT_ROWS - 1)) ? row_base + TEXT_AW'(COLS) : row_base;

  // state register
  always_ff @(posedge vga_clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // next state, font address and line buffer write port
  always_comb begin
    state_d   = state_q;
    font_addr = font_addr_q;
    buf_we    = 1'b0;
    buf_wdata = PIX_OFF;
    case (state_q)
      IDLE: begin
        if (pending) begin
          state_d = FETCH_CHAR;
        end
      end
      FETCH_CHAR: begin
        state_d = FETCH_FONT;
      end
      FETCH_FONT: begin
        font_addr = FONT_AW'({text_data[7:0], scan_row});
        state_d   = WRITE;
      end
      WRITE: begin
        buf_we = 1'b1;
`ifdef ATTR_EN
        buf_wdata = cur_bit ? {4'h0, attr_q[7:4]} : {4'h0, attr_q[3:0]};
`else
        buf_wdata = mono_pixel(cur_bit);
`endif
        if (last_bit) begin
          state_d = NEXT;
        end
      end
      NEXT: begin
        state_d = last_col ? IDLE : FETCH_CHAR;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    if (render_start) begin
      state_d = FETCH_CHAR;
    end
    if (render_reset) begin
      state_d = IDLE;
    end
  end

  // datapath: counters, request queue, fetch addresses and pixel shifter
  always_ff @(posedge vga_clk) begin
    if (reset) begin
      text_addr   <= '0;
      font_addr_q <= '0;
      busy        <= 1'b0;
      line_done   <= 1'b0;
      overrun     <= 1'b0;
      write_buf   <= 1'b0;
      scan_row    <= '0;
      row_base    <= '0;
      pending     <= 1'b0;
      col         <= '0;
      wr_ptr      <= '0;
      bit_cnt     <= '0;
      shift_q     <= '0;
`ifdef ATTR_EN
      attr_q      <= '0;
`endif
    end else begin
      line_done <= 1'b0;
      if (render_reset) begin
        busy      <= 1'b0;
        pending   <= 1'b0;
        write_buf <= 1'b0;
        scan_row  <= '0;
        row_base  <= '0;
        bit_cnt   <= '0;
      end else if (render_start) begin
        busy      <= 1'b1;
        pending   <= 1'b0;
        write_buf <= 1'b0;
        scan_row  <= '0;
        row_base  <= '0;
        col       <= '0;
        wr_ptr    <= '0;
        bit_cnt   <= '0;
        text_addr <= '0;
      end else begin
        if (line_advance) begin
          if (pending) begin
            overrun <= 1'b1;
          end
          pending <= 1'b1;
        end
        case (state_q)
          IDLE: begin
            if (pending) begin
              // an advance arriving in this same cycle stays queued for the following line
              pending   <= line_advance;
              busy      <= 1'b1;
              write_buf <= adv_buf;
              scan_row  <= adv_row;
              row_base  <= adv_base;
              col       <= '0;
              wr_ptr    <= adv_buf ? BUF_AW'(LINE_W) : '0;
              text_addr <= adv_base;
            end
          end
          FETCH_FONT: begin
            font_addr_q <= font_addr;
`ifdef ATTR_EN
            attr_q      <= text_data[15:8];
`endif
          end
          WRITE: begin
            wr_ptr  <= wr_ptr + BUF_AW'(1);
            bit_cnt <= bit_cnt + 3'd1;
            shift_q <= (bit_cnt == 3'd0) ? {font_data[6:0], 1'b0} : {shift_q[6:0], 1'b0};
          end
          NEXT: begin
            if (last_col) begin
              line_done <= 1'b1;
              busy      <= 1'b0;
            end else begin
              col       <= col_next;
              text_addr <= row_base + TEXT_AW'(col_next);
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

  line_buffer_dp #(
    .DEPTH(2 * LINE_W),
    .AW   (BUF_AW),
    .DW   (8)
  ) u_line_buffer (
    .clk  (vga_clk),
    .reset(reset),
    .we   (buf_we),
    .waddr(wr_ptr),
    .wdata(buf_wdata),
    .raddr(pixel_buffer_index_in),
    .rdata(pixel)
  );

endmodule

// File: tb/tb_text_line_renderer.sv
// tb/tb_text_line_renderer.sv - directed self-checking bench for text_line_renderer (ATTR_EN aware)
module tb_text_line_renderer;

`ifdef ATTR_EN
  localparam int TW = 16;
  localparam logic [7:0] ON2  = 8'h0A;
  localparam logic [7:0] OFF2 = 8'h03;
`else
  localparam int TW = 8;
  localparam logic [7:0] ON2  = 8'h01;
  localparam logic [7:0] OFF2 = 8'h00;
`endif

  logic          vga_clk = 1'b0;
  logic          reset;
  logic          render_reset;
  logic          render_start;
  logic          line_advance;
  logic [11:0]   text_addr;
  logic [TW-1:0] text_data;
  logic [10:0]   font_addr;
  logic [7:0]    font_data;
  logic [10:0]   pixel_buffer_index_in;
  logic [7:0]    pixel;
  logic          busy;
  logic          line_done;
  logic          overrun;

  logic [TW-1:0] text_mem [0:4095];
  logic [7:0]    font_mem [0:2047];

  int checks = 0;
  int errors = 0;

  always #5 vga_clk = ~vga_clk;

  always @(posedge vga_clk) begin
    text_data <= text_mem[text_addr];
    font_data <= font_mem[font_addr];
  end

  text_line_renderer dut (
    .vga_clk              (vga_clk),
    .reset                (reset),
    .render_reset         (render_reset),
    .render_start         (render_start),
    .line_advance         (line_advance),
    .text_addr            (text_addr),
    .text_data            (text_data),
    .font_addr            (font_addr),
    .font_data            (font_data),
    .pixel_buffer_index_in(pixel_buffer_index_in),
    .pixel                (pixel),
    .busy                 (busy),
    .line_done            (line_done),
    .overrun              (overrun)
  );

  task automatic tick(input int n);
    repeat (n) @(posedge vga_clk);
    #1;
  endtask

  task automatic read_pix(input logic [10:0] idx, output logic [7:0] val);
    pixel_buffer_index_in = idx;
    tick(1);
    val = pixel;
  endtask

  task automatic wait_done(input int limit, output int waited);
    waited = 0;
    while (line_done !== 1'b1 && waited < limit) begin
      tick(1);
      waited++;
    end
  endtask

  task automatic pulse_start;
    render_start = 1'b1;
    tick(1);
    render_start = 1'b0;
  endtask

  task automatic pulse_advance;
    line_advance = 1'b1;
    tick(1);
    line_advance = 1'b0;
  endtask

  task automatic init_mem;
    for (int i = 0; i < 4096; i++) text_mem[i] = '0;
    for (int i = 0; i < 2048; i++) font_mem[i] = 8'h00;
`ifdef ATTR_EN
    for (int i = 0; i < 4096; i++) text_mem[i] = {8'h10, 8'h20};
    text_mem[0]  = {8'h10, 8'h41};
    text_mem[1]  = {8'h10, 8'h42};
    text_mem[2]  = {8'hA3, 8'h45};
    text_mem[79] = {8'h10, 8'h43};
    text_mem[80] = {8'h10, 8'h44};
`else
    for (int i = 0; i < 4096; i++) text_mem[i] = 8'h20;
    text_mem[0]  = 8'h41;
    text_mem[1]  = 8'h42;
    text_mem[2]  = 8'h45;
    text_mem[79] = 8'h43;
    text_mem[80] = 8'h44;
`endif
    font_mem[11'h41 * 8 + 0] = 8'b1000_0001;
    font_mem[11'h41 * 8 + 1] = 8'h3C;
    font_mem[11'h42 * 8 + 0] = 8'hFF;
    font_mem[11'h45 * 8 + 0] = 8'hF0;
    font_mem[11'h43 * 8 + 0] = 8'h01;
    font_mem[11'h44 * 8 + 0] = 8'h80;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    render_reset = 1'b0;
    render_start = 1'b0;
    line_advance = 1'b0;
    pixel_buffer_index_in = '0;
    tick(3);
    reset = 1'b0;
    checks++; if (text_addr !== 12'd0) begin errors++; $display("FAIL reset text_addr: got %h expected 000", text_addr); end
    checks++; if (font_addr !== 11'd0) begin errors++; $display("FAIL reset font_addr: got %h expected 000", font_addr); end
    checks++; if (pixel !== 8'h00) begin errors++; $display("FAIL reset pixel: got %h expected 00", pixel); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset busy: got %b expected 0", busy); end
    checks++; if (line_done !== 1'b0) begin errors++; $display("FAIL reset line_done: got %b expected 0", line_done); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset overrun: got %b expected 0", overrun); end
  endtask

  task automatic test_first_line;
    logic [10:0] idx [12];
    logic [7:0]  exp [12];
    logic [7:0]  v;
    idx = '{11'd0, 11'd1, 11'd6, 11'd7, 11'd8, 11'd15, 11'd16, 11'd19, 11'd20, 11'd23, 11'd632, 11'd639};
    exp = '{8'h01, 8'h00, 8'h00, 8'h01, 8'h01, 8'h01, ON2, ON2, OFF2, OFF2, 8'h00, 8'h01};
    pulse_start;
    checks++; if (text_addr !== 12'd0) begin errors++; $display("FAIL first text_addr: got %h expected 000", text_addr); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL first busy: got %b expected 1", busy); end
    tick(1);
    checks++; if (font_addr !== 11'h208) begin errors++; $display("FAIL first font_addr: got %h expected 208", font_addr); end
    tick(878);
    checks++; if (line_done !== 1'b0) begin errors++; $display("FAIL first line_done early: got %b expected 0", line_done); end
    tick(1);
    checks++; if (line_done !== 1'b1) begin errors++; $display("FAIL first line_done at 880: got %b expected 1", line_done); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL first busy after line: got %b expected 0", busy); end
    tick(1);
    checks++; if (line_done !== 1'b0) begin errors++; $display("FAIL first line_done pulse width: got %b expected 0", line_done); end
    for (int i = 0; i < 12; i++) begin
      read_pix(idx[i], v);
      checks++; if (v !== exp[i]) begin errors++; $display("FAIL first buf[%0d]: got %h expected %h", idx[i], v, exp[i]); end
    end
  endtask

  task automatic test_line_advance;
    logic [10:0] idx [5];
    logic [7:0]  exp [5];
    logic [7:0]  v;
    int w;
    idx = '{11'd640, 11'd642, 11'd645, 11'd647, 11'd0};
    exp = '{8'h00, 8'h01, 8'h01, 8'h00, 8'h01};
    pulse_advance;
    tick(1);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL adv busy: got %b expected 1", busy); end
    checks++; if (text_addr !== 12'd0) begin errors++; $display("FAIL adv text_addr: got %h expected 000", text_addr); end
    tick(1);
    checks++; if (font_addr !== 11'h209) begin errors++; $display("FAIL adv font_addr: got %h expected 209", font_addr); end
    wait_done(1000, w);
    checks++; if (w >= 1000) begin errors++; $display("FAIL adv line_done timeout: got %0d cycles expected < 1000", w); end
    for (int i = 0; i < 5; i++) begin
      read_pix(idx[i], v);
      checks++; if (v !== exp[i]) begin errors++; $display("FAIL adv buf[%0d]: got %h expected %h", idx[i], v, exp[i]); end
    end
  endtask

  task automatic test_row_wrap;
    logic [7:0] v;
    int w;
    pulse_start;
    wait_done(1000, w);
    checks++; if (w >= 1000) begin errors++; $display("FAIL wrap line0 timeout: got %0d expected < 1000", w); end
    for (int k = 1; k <= 7; k++) begin
      pulse_advance;
      wait_done(1000, w);
      checks++; if (w >= 1000) begin errors++; $display("FAIL wrap line%0d timeout: got %0d expected < 1000", k, w); end
    end
    read_pix(11'd0, v);
    checks++; if (v !== 8'h00) begin errors++; $display("FAIL wrap buf[0] before: got %h expected 00", v); end
    pulse_advance;
    tick(1);
    checks++; if (text_addr !== 12'd80) begin errors++; $display("FAIL wrap text_addr col0: got %0d expected 80", text_addr); end
    checks++; if (pixel !== 8'h00) begin errors++; $display("FAIL wrap pixel start: got %h expected 00", pixel); end
    tick(3);
    checks++; if (pixel !== 8'h00) begin errors++; $display("FAIL wrap read-during-write: got %h expected 00", pixel); end
    tick(1);
    checks++; if (pixel !== 8'h01) begin errors++; $display("FAIL wrap read-after-write: got %h expected 01", pixel); end
    tick(7);
    checks++; if (text_addr !== 12'd81) begin errors++; $display("FAIL wrap text_addr col1: got %0d expected 81", text_addr); end
    wait_done(1000, w);
    checks++; if (w >= 1000) begin errors++; $display("FAIL wrap line8 timeout: got %0d expected < 1000", w); end
    read_pix(11'd1, v);
    checks++; if (v !== 8'h00) begin errors++; $display("FAIL wrap buf[1]: got %h expected 00", v); end
    read_pix(11'd8, v);
    checks++; if (v !== 8'h00) begin errors++; $display("FAIL wrap buf[8]: got %h expected 00", v); end
  endtask

  task automatic test_back_to_back;
    logic [7:0] v;
    int w;
    read_pix(11'd642, v);
    checks++; if (v !== 8'h00) begin errors++; $display("FAIL b2b buf[642] before: got %h expected 00", v); end
    pulse_start;
    tick(100);
    pulse_advance;
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL b2b overrun after first: got %b expected 0", overrun); end
    tick(5);
    pulse_advance;
    checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL b2b overrun after second: got %b expected 1", overrun); end
    wait_done(1000, w);
    checks++; if (w >= 1000) begin errors++; $display("FAIL b2b first line timeout: got %0d expected < 1000", w); end
    tick(1);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b extra line start: got %b expected 1", busy); end
    wait_done(1000, w);
    checks++; if (w >= 1000) begin errors++; $display("FAIL b2b extra line timeout: got %0d expected < 1000", w); end
    tick(20);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b only one extra line: got %b expected 0", busy); end
    checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL b2b overrun sticky: got %b expected 1", overrun); end
    read_pix(11'd642, v);
    checks++; if (v !== 8'h01) begin errors++; $display("FAIL b2b buf[642] after: got %h expected 01", v); end
  endtask

  task automatic test_render_reset;
    logic [7:0] v;
    int w;
    int unstable;
    pulse_advance;
    tick(4);
    render_reset = 1'b1;
    tick(1);
    render_reset = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rreset busy: got %b expected 0", busy); end
    checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL rreset overrun kept: got %b expected 1", overrun); end
    tick(10);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rreset stays idle: got %b expected 0", busy); end
    render_start = 1'b1;
    line_advance = 1'b1;
    tick(1);
    render_start = 1'b0;
    line_advance = 1'b0;
    checks++; if (text_addr !== 12'd0) begin errors++; $display("FAIL rreset restart text_addr: got %h expected 000", text_addr); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rreset restart busy: got %b expected 1", busy); end
    unstable = 0;
    for (int i = 0; i < 50; i++) begin
      read_pix(11'd642, v);
      if (v !== 8'h01) unstable++;
    end
    checks++; if (unstable != 0) begin errors++; $display("FAIL rreset other-half read: got %0d bad reads expected 0", unstable); end
    wait_done(1000, w);
    checks++; if (w >= 1000) begin errors++; $display("FAIL rreset restart timeout: got %0d expected < 1000", w); end
    tick(20);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rreset start beats advance: got %b expected 0", busy); end
    read_pix(11'd0, v);
    checks++; if (v !== 8'h01) begin errors++; $display("FAIL rreset buf[0]: got %h expected 01", v); end
    read_pix(11'd16, v);
    checks++; if (v !== ON2) begin errors++; $display("FAIL rreset buf[16]: got %h expected %h", v, ON2); end
  endtask

  initial begin
    init_mem();
    test_reset();
    test_first_line();
    test_line_advance();
    test_row_wrap();
    test_back_to_back();
    test_render_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/text_line_renderer.md
Name: text_line_renderer

Overview:
Upstream feeder of the VGA output stage. Renders one scan line of 8x8 text into a 1280-entry double line buffer: half 0 at 0..639, half 1 at 640..1279. For each character it fetches the code from text RAM and the bitmap from font RAM, then writes 8 pixels. The VGA stage reads the other half through a registered read port.

Parameters:
COLS, 80, characters per text row
FONT_ROWS, 8, scan lines per character row (power of two)
LINE_W, 640, pixels per line and offset of buffer half 1
TEXT_AW, 12, text RAM address width
FONT_AW, 11, font RAM address width (char*8+row)

Ports:
vga_clk  in  1  sole clock
reset  in  1  synchronous, active-high
render_reset  in  1  level; aborts rendering and rewinds to frame top
render_start  in  1  pulse; render source line 0 into half 0
line_advance  in  1  pulse; display moved to a new half, render next line into the other half
text_addr  out  TEXT_AW  text RAM address
text_data  in  8 (16 with ATTR_EN)  char code [7:0], attribute [15:8]; valid 1 cycle after address
font_addr  out  FONT_AW  font RAM address
font_data  in  8  bitmap row, MSB = leftmost pixel; valid 1 cycle after address
pixel_buffer_index_in  in  11  read address from VGA stage
pixel  out  8  registered read data, 1-cycle latency
busy  out  1  rendering a line
line_done  out  1  1-cycle pulse when the last pixel of a line is written
overrun  out  1  sticky; a request arrived while one was already pending

Behaviour:
- Reset values: text_addr=0, font_addr=0, pixel=0, busy=0, line_done=0, overrun=0. Internal state: write_buf=0, scan_row=0, row_base=0, pending=0, FSM=IDLE. Buffer contents are not cleared.
- FSM states: IDLE, FETCH_CHAR, FETCH_FONT, WRITE, NEXT.
  - IDLE: starts on request (render_start, or pending). busy=1, col=0, wr_ptr = write_buf ? LINE_W : 0.
  - FETCH_CHAR: drive text_addr=row_base+col, wait 1 cycle.
  - FETCH_FONT: drive font_addr={text_data[7:0], scan_row[2:0]}; latch attribute; wait 1 cycle.
  - WRITE: 8 cycles; load shift reg from font_data, write 1 pixel per cycle at wr_ptr, wr_ptr++.
  - NEXT: if col==COLS-1, pulse line_done, busy=0, go IDLE; else col++ and go FETCH_CHAR.
  - Timing: 11 cycles per char, 880 cycles per 80-col line. This fits the 2-scanline display window of each half.
- render_start: write_buf=0, scan_row=0, row_base=0, start immediately, clears pending.
- line_advance:
  - Toggles write_buf; scan_row = (scan_row+1) mod FONT_ROWS.
  - When scan_row wraps to 0: row_base += COLS. No multiplier; row_base wraps at 2^TEXT_AW.
  - Counters update on the next line start, not mid-line.
  - If busy: set pending. If pending is already 1: set overrun and keep one pending request.
- render_reset: same cycle → FSM=IDLE, busy=0, pending=0, write_buf=0, scan_row=0, row_base=0. A partial line stays in the buffer.
  - Dominates render_start and line_advance in the same cycle.
  - overrun is cleared only by reset.
- render_start and line_advance in the same cycle: render_start wins.
- Pixel value: bit set → 8'h01, clear → 8'h00.
- Line buffer is true dual-port: read and write to the same address in the same cycle → read returns old data.
- Writes outside 0..1279 are impossible by construction.

Optional Feature:
ATTR_EN
- Defined: text_data is 16 bits. Pixel = attribute[7:4] for set bits, attribute[3:0] for clear bits, zero-extended to 8 bits.
- Undefined: text_data is 8 bits, pixels are 8'h01/8'h00, no attribute register.

Decomposition:
- Package chroni_render_pkg holds:
  - FSM state enum.
  - PIX_ON=8'h01, PIX_OFF=8'h00.
  - BUF_DEPTH=2*LINE_W.
- Sub-module line_buffer_dp:
  - 1280x8, one write port, one registered read port.
  - Instantiated once.

Test Plan:
- render_start, text RAM col0=8'h41, font row0 of 0x41=8'b1000_0001 → buffer[0]=01, [1..6]=00, [7]=01. line_done 880 cycles after start.
- line_advance after line_done → writes at 640..1279 with scan_row=1; font_addr=0x209 for char 0x41.
- 8 line_advances → row_base=80; text_addr sequence for the 9th line starts at 80.
- line_advance twice while busy → one extra line rendered; overrun=1 after the second, stays 1.
- render_reset mid-WRITE → next cycle busy=0. Following render_start restarts at text_addr=0, half 0.
- ATTR_EN, attribute 8'hA3, bitmap 8'hF0 → pixels 0A,0A,0A,0A,03,03,03,03. Read during write to a different half returns stable data.
